// File: rtl/rf_operand_fetch_pkg.sv
// Shared definitions for the operand-fetch block: parameter defaults and FSM encoding.
package rf_operand_fetch_pkg;

  localparam int unsigned M_DEF = 3;  // register address width
  localparam int unsigned N_DEF = 8;  // data width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_CAPT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/rf_operand_fetch_scoreboard.sv
// Busy-register scoreboard: tracks in-flight destinations and flags read/write hazards.
module rf_scoreboard
  import rf_operand_fetch_pkg::*;
#(
  parameter int unsigned M = M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_en,
  input  logic [M-1:0] set_idx,
  input  logic         clr_en,
  input  logic [M-1:0] clr_idx,
  input  logic [M-1:0] dst,
  input  logic [M-1:0] ra,
  input  logic [M-1:0] rb,
  input  logic         usea,
  input  logic         useb,
  output logic         hazard,
  output logic         clr_idle
);

  localparam int unsigned R = 2**M;

  logic [R-1:0] busy;

  // Busy bits: set on issue, clear on writeback; set wins on a same-index collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < R; i++) begin
        if (set_en && (set_idx == M'(i))) begin
          busy[i] <= 1'b1;
        end else if (clr_en && (clr_idx == M'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // Hazard lookup against the registered vector only, so a cleared register stalls one cycle
  always_comb begin
    hazard   = (usea && busy[ra]) || (useb && busy[rb]) || busy[dst];
    clr_idle = clr_en && !busy[clr_idx];
  end

endmodule

// File: rtl/rf_operand_fetch.sv
// Operand fetch stage: accepts a request, waits out scoreboard hazards, reads the
// register file, and presents operands to the execution unit.
module rf_operand_fetch
  import rf_operand_fetch_pkg::*;
#(
  parameter int unsigned M = M_DEF,
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [M-1:0] req_dst,
  input  logic [M-1:0] req_ra,
  input  logic [M-1:0] req_rb,
  input  logic         req_usea,
  input  logic         req_useb,
  output logic [M-1:0] rf_ra,
  output logic [M-1:0] rf_rb,
  output logic         rf_reada,
  output logic         rf_readb,
  input  logic [N-1:0] rf_qa,
  input  logic [N-1:0] rf_qb,
  output logic [M-1:0] rf_waddr,
  output logic [N-1:0] rf_wd,
  output logic         rf_write,
  output logic         op_valid,
  input  logic         op_ready,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic [M-1:0] op_dst,
  input  logic         wb_valid,
  input  logic [M-1:0] wb_dst,
  input  logic [N-1:0] wb_data,
  output logic         wb_err
);

  state_t       state, state_nxt;
  logic [M-1:0] dst_q, ra_q, rb_q;
  logic         usea_q, useb_q;
  logic         hazard, clr_idle, issue;

  rf_scoreboard #(.M(M)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue),
    .set_idx  (dst_q),
    .clr_en   (wb_valid),
    .clr_idx  (wb_dst),
    .dst      (dst_q),
    .ra       (ra_q),
    .rb       (rb_q),
    .usea     (usea_q),
    .useb     (useb_q),
    .hazard   (hazard),
    .clr_idle (clr_idle)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (req_valid) state_nxt = S_READ;
      S_READ: if (!hazard)   state_nxt = S_CAPT;
      S_CAPT:                state_nxt = S_OUT;
      S_OUT:  if (op_ready)  state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs and register-file port wiring
  always_comb begin
    req_ready = (state == S_IDLE);
    op_valid  = (state == S_OUT);
    issue     = (state == S_READ) && !hazard;
    rf_reada  = issue && usea_q;
    rf_readb  = issue && useb_q;
    rf_ra     = ra_q;
    rf_rb     = rb_q;
    rf_write  = wb_valid;
    rf_waddr  = wb_dst;
    rf_wd     = wb_data;
  end

  // Request latch on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dst_q  <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      usea_q <= 1'b0;
      useb_q <= 1'b0;
    end else if ((state == S_IDLE) && req_valid) begin
      dst_q  <= req_dst;
      ra_q   <= req_ra;
      rb_q   <= req_rb;
      usea_q <= req_usea;
      useb_q <= req_useb;
    end
  end

  // Operand capture one cycle after the read enable; unused sources read as zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a   <= '0;
      op_b   <= '0;
      op_dst <= '0;
    end else if (state == S_CAPT) begin
      op_a   <= usea_q ? rf_qa : '0;
      op_b   <= useb_q ? rf_qb : '0;
      op_dst <= dst_q;
    end
  end

  // Sticky error for writeback to a register that had no pending issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          wb_err <= 1'b0;
    else if (clr_idle) wb_err <= 1'b1;
  end

endmodule
